// File: rtl/reg_bank_reader.sv
// Reads one bank register (EDY low RD_LAT cycles) and streams it LSB-first on a valid/ready serial link;
// SREADY low stalls the current bit. Define REG_BANK_READER_PARITY_EN to append an even-parity bit.
module reg_bank_reader #(
  parameter int NUMBITS = 8,
  parameter int NREGS   = 4,
  parameter int ADDRW   = 2,
  parameter int RD_LAT  = 1
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic [ADDRW-1:0]   ADDR,
  output logic [ADDRW-1:0]   REG_SEL,
  output logic               EDY,
  input  logic [NUMBITS-1:0] RDATA,
  output logic               SOUT,
  output logic               SVALID,
  input  logic               SREADY,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  localparam int RCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int BCW = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;

`ifdef REG_BANK_READER_PARITY_EN
  typedef enum logic [2:0] {IDLE, READ, SHIFT, PAR, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SHIFT, FIN} state_t;
`endif

  state_t             state, state_nxt;
  logic [ADDRW-1:0]   reg_sel;
  logic               err_flag;
  logic [RCW-1:0]     rd_cnt;
  logic [BCW-1:0]     bit_cnt;
  logic [NUMBITS-1:0] shreg;
  logic               addr_ok;
  logic               rd_last;
  logic               bit_last;
`ifdef REG_BANK_READER_PARITY_EN
  logic               par_bit;
`endif

  assign addr_ok  = (32'(ADDR) < 32'(NREGS));
  assign rd_last  = (rd_cnt == RCW'(RD_LAT - 1));
  assign bit_last = (bit_cnt == BCW'(NUMBITS - 1));
  assign REG_SEL  = reg_sel;

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    EDY       = 1'b1;
    SVALID    = 1'b0;
    SOUT      = 1'b0;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    ERR       = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) state_nxt = addr_ok ? READ : FIN;
      end
      READ: begin
        EDY = 1'b0;
        if (rd_last) state_nxt = SHIFT;
      end
      SHIFT: begin
        SVALID = 1'b1;
        SOUT   = shreg[0];
`ifdef REG_BANK_READER_PARITY_EN
        if (SREADY && bit_last) state_nxt = PAR;
`else
        if (SREADY && bit_last) state_nxt = FIN;
`endif
      end
`ifdef REG_BANK_READER_PARITY_EN
      PAR: begin
        SVALID = 1'b1;
        SOUT   = par_bit;
        if (SREADY) state_nxt = FIN;
      end
`endif
      FIN: begin
        DONE      = 1'b1;
        ERR       = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RDATA is only captured on the last EDY-low cycle; the bank drives X otherwise.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      reg_sel  <= '0;
      err_flag <= 1'b0;
      rd_cnt   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef REG_BANK_READER_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            reg_sel  <= ADDR;
            err_flag <= !addr_ok;
            rd_cnt   <= '0;
            bit_cnt  <= '0;
          end
        end
        READ: begin
          if (rd_last) begin
            shreg <= RDATA;
`ifdef REG_BANK_READER_PARITY_EN
            par_bit <= ^RDATA;
`endif
          end else begin
            rd_cnt <= rd_cnt + RCW'(1);
          end
        end
        SHIFT: begin
          if (SREADY) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
